// File: rtl/sensor_readout_sequencer.sv
// -----------------------------------------------------------------------------
// sensor_readout_sequencer
//
// Purpose:
//   Produces frame/line framing for mapping_controller from a programmable
//   frame geometry (active width, horizontal blanking, line count, vertical
//   blanking). It also drives the even/odd channel group select that folds the
//   16 trained channels onto the 8 parallel outputs. Single-shot and
//   continuous capture are supported. A stop request always lets the current
//   frame finish.
//
// Ports (all synchronous to clk_rxg except the reset):
//   clk_rxg         receive-side pixel clock, rising edge
//   rst_rx_n        active-low reset, asserts asynchronously
//   start           one-cycle capture request (honoured only in IDLE)
//   stop            one-cycle request to end continuous capture after the
//                   current frame
//   cfg_continuous  1 = free-run frames, 0 = single frame
//   cfg_line_len    active pixels per line (clocks)
//   cfg_hblank      clocks between lines
//   cfg_lines       lines per frame
//   cfg_vblank      clocks between frames
//   fvals_map       frame valid
//   lvals_map       line valid
//   grp_sel         channel group select, 0 = even, 1 = odd
//   col_cnt         column index inside the active line
//   row_cnt         current line index
//   frame_cnt       completed frames, wraps modulo 2^FCNT_W
//   frame_done      one-cycle pulse on the first vertical blanking cycle
//   busy            high whenever the sequencer is not IDLE
//   cfg_err         one-cycle pulse when a start is rejected for bad config
// -----------------------------------------------------------------------------
module sensor_readout_sequencer #(
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 16
) (
  input  logic              clk_rxg,
  input  logic              rst_rx_n,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_continuous,
  input  logic [CNT_W-1:0]  cfg_line_len,
  input  logic [CNT_W-1:0]  cfg_hblank,
  input  logic [CNT_W-1:0]  cfg_lines,
  input  logic [CNT_W-1:0]  cfg_vblank,
  output logic              fvals_map,
  output logic              lvals_map,
  output logic              grp_sel,
  output logic [CNT_W-1:0]  col_cnt,
  output logic [CNT_W-1:0]  row_cnt,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              frame_done,
  output logic              busy,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  // ---------------------------------------------------------------------------
  // State, counters and shadow configuration
  // ---------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   col_reg, col_next;
  logic [CNT_W-1:0]   row_reg, row_next;
  logic [CNT_W-1:0]   blank_reg, blank_next;
  logic [FCNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic               stop_pending_reg, stop_pending_next;

  logic [CNT_W-1:0]   sh_line_len_reg;
  logic [CNT_W-1:0]   sh_hblank_reg;
  logic [CNT_W-1:0]   sh_lines_reg;
  logic [CNT_W-1:0]   sh_vblank_reg;
  logic               sh_continuous_reg;

  // Registered outputs
  logic               fvals_reg, fvals_next;
  logic               lvals_reg, lvals_next;
  logic               grp_sel_reg, grp_sel_next;
  logic               frame_done_reg, frame_done_next;
  logic               busy_reg, busy_next;
  logic               cfg_err_reg, cfg_err_next;

  logic               cfg_valid;
  logic               latch_cfg;
  logic [CNT_W-1:0]   last_col;
  logic [CNT_W-1:0]   last_row;
  logic [CNT_W-1:0]   last_hblank;
  logic [CNT_W-1:0]   last_vblank;

  // Every geometry field must be nonzero, otherwise a terminal count of
  // "field - 1" would underflow and the counters would run to all-ones.
  assign cfg_valid = (|cfg_line_len) && (|cfg_hblank) &&
                     (|cfg_lines) && (|cfg_vblank);

  // Terminal counts come from the shadow copy, so the live config inputs
  // can change freely while a frame is in flight.
  assign last_col    = sh_line_len_reg - CNT_ONE;
  assign last_row    = sh_lines_reg    - CNT_ONE;
  assign last_hblank = sh_hblank_reg   - CNT_ONE;
  assign last_vblank = sh_vblank_reg   - CNT_ONE;

  // ---------------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      state_reg        <= IDLE;
      col_reg          <= '0;
      row_reg          <= '0;
      blank_reg        <= '0;
      frame_cnt_reg    <= '0;
      stop_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      col_reg          <= col_next;
      row_reg          <= row_next;
      blank_reg        <= blank_next;
      frame_cnt_reg    <= frame_cnt_next;
      stop_pending_reg <= stop_pending_next;
    end
  end

  // Shadow configuration, captured on an accepted start and at each
  // continuous-mode frame boundary.
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      sh_line_len_reg   <= '0;
      sh_hblank_reg     <= '0;
      sh_lines_reg      <= '0;
      sh_vblank_reg     <= '0;
      sh_continuous_reg <= 1'b0;
    end else if (latch_cfg) begin
      sh_line_len_reg   <= cfg_line_len;
      sh_hblank_reg     <= cfg_hblank;
      sh_lines_reg      <= cfg_lines;
      sh_vblank_reg     <= cfg_vblank;
      sh_continuous_reg <= cfg_continuous;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    col_next          = col_reg;
    row_next          = row_reg;
    blank_next        = blank_reg;
    frame_cnt_next    = frame_cnt_reg;
    stop_pending_next = stop_pending_reg;
    frame_done_next   = 1'b0;
    cfg_err_next      = 1'b0;
    latch_cfg         = 1'b0;

    // A stop seen while busy is remembered until the frame ends. The
    // VBLANK exit below still sees the raw stop, so a stop arriving on
    // the very last blanking cycle is honoured too.
    if (state_reg != IDLE && stop) begin
      stop_pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        stop_pending_next = 1'b0;
        if (start) begin
          if (cfg_valid) begin
            latch_cfg  = 1'b1;
            state_next = LINE;
            col_next   = '0;
            row_next   = '0;
            blank_next = '0;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      LINE: begin
        if (col_reg == last_col) begin
          col_next   = '0;
          blank_next = '0;
          if (row_reg == last_row) begin
            state_next      = VBLANK;
            row_next        = '0;
            frame_done_next = 1'b1;
            frame_cnt_next  = frame_cnt_reg + FCNT_ONE;
          end else begin
            state_next = HBLANK;
          end
        end else begin
          col_next = col_reg + CNT_ONE;
        end
      end

      HBLANK: begin
        // row_cnt keeps showing the line just finished until the next one
        // starts.
        if (blank_reg == last_hblank) begin
          blank_next = '0;
          row_next   = row_reg + CNT_ONE;
          state_next = LINE;
        end else begin
          blank_next = blank_reg + CNT_ONE;
        end
      end

      VBLANK: begin
        if (blank_reg == last_vblank) begin
          blank_next = '0;
          // A new frame needs the live config to be valid, because it is
          // re-latched here. An invalid config ends capture cleanly
          // instead of running with a zero-length field.
          if (sh_continuous_reg && !stop_pending_reg && !stop && cfg_valid) begin
            latch_cfg  = 1'b1;
            state_next = LINE;
            col_next   = '0;
            row_next   = '0;
          end else begin
            state_next        = IDLE;
            stop_pending_next = 1'b0;
          end
        end else begin
          blank_next = blank_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every output is a flop aligned
  // with the state it describes.
  // ---------------------------------------------------------------------------
  always_comb begin
    fvals_next   = (state_next == LINE) || (state_next == HBLANK);
    lvals_next   = (state_next == LINE);
    // Column 0 is the even group, so the select simply follows the column LSB.
    grp_sel_next = (state_next == LINE) ? col_next[0] : 1'b0;
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      fvals_reg      <= 1'b0;
      lvals_reg      <= 1'b0;
      grp_sel_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      fvals_reg      <= fvals_next;
      lvals_reg      <= lvals_next;
      grp_sel_reg    <= grp_sel_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

  assign fvals_map  = fvals_reg;
  assign lvals_map  = lvals_reg;
  assign grp_sel    = grp_sel_reg;
  assign col_cnt    = col_reg;
  assign row_cnt    = row_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign frame_done = frame_done_reg;
  assign busy       = busy_reg;
  assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_sensor_readout_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for sensor_readout_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
// FCNT_W is set to 2 so the frame counter wrap can be reached quickly.
// -----------------------------------------------------------------------------
module tb_sensor_readout_sequencer;

  localparam int CNT_W  = 12;
  localparam int FCNT_W = 2;

  logic              clk_rxg;
  logic              rst_rx_n;
  logic              start;
  logic              stop;
  logic              cfg_continuous;
  logic [CNT_W-1:0]  cfg_line_len;
  logic [CNT_W-1:0]  cfg_hblank;
  logic [CNT_W-1:0]  cfg_lines;
  logic [CNT_W-1:0]  cfg_vblank;
  logic              fvals_map;
  logic              lvals_map;
  logic              grp_sel;
  logic [CNT_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  row_cnt;
  logic [FCNT_W-1:0] frame_cnt;
  logic              frame_done;
  logic              busy;
  logic              cfg_err;

  sensor_readout_sequencer #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .clk_rxg        (clk_rxg),
    .rst_rx_n       (rst_rx_n),
    .start          (start),
    .stop           (stop),
    .cfg_continuous (cfg_continuous),
    .cfg_line_len   (cfg_line_len),
    .cfg_hblank     (cfg_hblank),
    .cfg_lines      (cfg_lines),
    .cfg_vblank     (cfg_vblank),
    .fvals_map      (fvals_map),
    .lvals_map      (lvals_map),
    .grp_sel        (grp_sel),
    .col_cnt        (col_cnt),
    .row_cnt        (row_cnt),
    .frame_cnt      (frame_cnt),
    .frame_done     (frame_done),
    .busy           (busy),
    .cfg_err        (cfg_err)
  );

  initial clk_rxg = 1'b0;
  always #5 clk_rxg = ~clk_rxg;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One record per capture scenario: stimulus plus expected measurements.
  typedef struct {
    int line_len, hblank, lines, vblank, cont;
    int stop_at;          // cycle index of a stop pulse, -1 = none
    int stop_with_start;  // 1 = stop asserted together with start
    int restart_at;       // cycle index of a second start pulse, -1 = none
    int run;              // cycles observed after the start edge
    int e_rises, e_high, e_period, e_fcnt, e_done, e_busy, e_err;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    rst_rx_n = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    repeat (2) @(negedge clk_rxg);
    rst_rx_n = 1'b1;
    @(negedge clk_rxg);
  endtask

  task automatic set_cfg(input int ll, input int hb, input int ln, input int vb, input int cont);
    cfg_line_len   = CNT_W'(ll);
    cfg_hblank     = CNT_W'(hb);
    cfg_lines      = CNT_W'(ln);
    cfg_vblank     = CNT_W'(vb);
    cfg_continuous = (cont != 0);
  endtask

  // Start pulse driven at a falling edge. After the next falling edge,
  // the sample reflects the first cycle after the start edge (cycle 0).
  task automatic pulse_start(input logic with_stop);
    @(negedge clk_rxg);
    start = 1'b1;
    stop  = with_stop;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rises, first_rise, second_rise, high, done_n, busy_n, err_n, period;
    logic prev_f;
    rises = 0; first_rise = -1; second_rise = -1; high = 0;
    done_n = 0; busy_n = 0; err_n = 0; prev_f = 1'b0;
    do_reset();
    set_cfg(v.line_len, v.hblank, v.lines, v.vblank, v.cont);
    pulse_start(v.stop_with_start != 0);
    for (int c = 0; c < v.run; c++) begin
      @(negedge clk_rxg);
      start = (c == v.restart_at);
      stop  = (c == v.stop_at);
      if (fvals_map && !prev_f) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        else if (second_rise < 0) second_rise = c;
      end
      if (fvals_map && rises == 1) high++;
      done_n += int'(frame_done);
      busy_n += int'(busy);
      err_n  += int'(cfg_err);
      prev_f = fvals_map;
    end
    start = 1'b0;
    stop  = 1'b0;
    period = (second_rise < 0) ? 0 : second_rise - first_rise;
    check($sformatf("v%0d fval_rises", idx), rises, v.e_rises);
    check($sformatf("v%0d fval_high_len", idx), high, v.e_high);
    check($sformatf("v%0d frame_period", idx), period, v.e_period);
    check($sformatf("v%0d frame_cnt", idx), 32'(frame_cnt), v.e_fcnt);
    check($sformatf("v%0d frame_done_pulses", idx), done_n, v.e_done);
    check($sformatf("v%0d busy_cycles", idx), busy_n, v.e_busy);
    check($sformatf("v%0d cfg_err_pulses", idx), err_n, v.e_err);
    $display("vector %0d: ll=%0d hb=%0d ln=%0d vb=%0d cont=%0d rises=%0d high=%0d period=%0d fcnt=%0d busy=%0d err=%0d",
             idx, v.line_len, v.hblank, v.lines, v.vblank, v.cont, rises, high, period,
             frame_cnt, busy_n, err_n);
  endtask

  logic lv_hist[80];

  function automatic int run_len(input int from);
    int n = 0;
    for (int i = from; i < 80; i++) begin
      if (!lv_hist[i]) break;
      n++;
    end
    return n;
  endfunction

  initial begin
    logic [FCNT_W-1:0] fc_q[$];
    int p;
    logic in_line;

    //          ll hb ln vb cont stop_at sws restart run  rises high per fcnt done busy err
    vecs[0] = '{4, 2, 3, 5, 0,   -1,     0,  5,      40,  1,    16,  0,  1,   1,   21,  0};
    vecs[1] = '{4, 2, 3, 5, 1,   28,     0,  -1,     70,  2,    16,  21, 2,   2,   42,  0};
    vecs[2] = '{4, 0, 3, 5, 0,   -1,     0,  -1,     10,  0,    0,   0,  0,   0,   0,   1};
    vecs[3] = '{4, 2, 3, 0, 1,   -1,     0,  -1,     10,  0,    0,   0,  0,   0,   0,   1};
    vecs[4] = '{1, 1, 1, 1, 0,   -1,     0,  -1,     10,  1,    1,   0,  1,   1,   2,   0};
    vecs[5] = '{3, 1, 2, 2, 1,   0,      0,  -1,     20,  1,    7,   0,  1,   1,   9,   0};
    vecs[6] = '{4, 2, 3, 5, 1,   20,     0,  -1,     40,  1,    16,  0,  1,   1,   21,  0};
    vecs[7] = '{4, 2, 3, 5, 1,   -1,     1,  -1,     50,  3,    16,  21, 2,   2,   50,  0};

    rst_rx_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset state
    do_reset();
    check("reset fvals_map", fvals_map, 0);
    check("reset lvals_map", lvals_map, 0);
    check("reset grp_sel", grp_sel, 0);
    check("reset col_cnt", col_cnt, 0);
    check("reset row_cnt", row_cnt, 0);
    check("reset frame_cnt", 32'(frame_cnt), 0);
    check("reset frame_done", frame_done, 0);
    check("reset busy", busy, 0);
    check("reset cfg_err", cfg_err, 0);

    // Table-driven scenarios
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Cycle-exact single-shot frame: 4/2/3/5
    do_reset();
    set_cfg(4, 2, 3, 5, 0);
    pulse_start(1'b0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk_rxg);
      start = 1'b0;
      p = c % 6;
      in_line = (c < 16) && (p < 4);
      check($sformatf("c%0d fvals_map", c), fvals_map, (c < 16) ? 1 : 0);
      check($sformatf("c%0d lvals_map", c), lvals_map, in_line ? 1 : 0);
      check($sformatf("c%0d grp_sel", c), grp_sel, in_line ? (p % 2) : 0);
      check($sformatf("c%0d col_cnt", c), col_cnt, in_line ? p : 0);
      check($sformatf("c%0d row_cnt", c), row_cnt, (c < 16) ? (c / 6) : 0);
      check($sformatf("c%0d frame_done", c), frame_done, (c == 16) ? 1 : 0);
      check($sformatf("c%0d frame_cnt", c), 32'(frame_cnt), (c < 16) ? 0 : 1);
      check($sformatf("c%0d busy", c), busy, (c < 21) ? 1 : 0);
      $display("cycle %0d: f=%0d l=%0d g=%0d col=%0d row=%0d done=%0d fcnt=%0d busy=%0d",
               c, fvals_map, lvals_map, grp_sel, col_cnt, row_cnt, frame_done, frame_cnt, busy);
    end

    // Asynchronous reset in the middle of line 1
    do_reset();
    set_cfg(4, 2, 3, 5, 0);
    pulse_start(1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_rxg);
      start = 1'b0;
    end
    check("pre-reset row_cnt", row_cnt, 1);
    check("pre-reset col_cnt", col_cnt, 1);
    #2 rst_rx_n = 1'b0;
    #1;
    check("async reset fvals_map", fvals_map, 0);
    check("async reset lvals_map", lvals_map, 0);
    check("async reset grp_sel", grp_sel, 0);
    check("async reset col_cnt", col_cnt, 0);
    check("async reset row_cnt", row_cnt, 0);
    check("async reset busy", busy, 0);
    @(negedge clk_rxg);
    rst_rx_n = 1'b1;
    repeat (3) @(negedge clk_rxg);
    check("post-reset busy", busy, 0);
    check("post-reset fvals_map", fvals_map, 0);
    $display("reset mid-frame: busy=%0d fvals=%0d", busy, fvals_map);

    // Config change mid-frame: line_len 4 -> 8 during frame 1
    do_reset();
    set_cfg(4, 2, 3, 5, 1);
    pulse_start(1'b0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_rxg);
      start = 1'b0;
      if (c == 3) cfg_line_len = CNT_W'(8);
      lv_hist[c] = lvals_map;
    end
    check("cfgchg frame1 line0 len", run_len(0), 4);
    check("cfgchg frame1 line2 len", run_len(12), 4);
    check("cfgchg frame2 line0 len", run_len(21), 8);
    check("cfgchg frame2 line1 len", run_len(31), 8);
    $display("config change: f1 line=%0d f2 line=%0d", run_len(0), run_len(21));

    // frame_cnt wrap with a 2-bit counter
    do_reset();
    set_cfg(4, 2, 3, 5, 1);
    pulse_start(1'b0);
    for (int c = 0; c < 200 && fc_q.size() < 5; c++) begin
      @(negedge clk_rxg);
      start = 1'b0;
      if (frame_done) fc_q.push_back(frame_cnt);
    end
    stop = 1'b1;
    @(negedge clk_rxg);
    stop = 1'b0;
    check("wrap frames seen", fc_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < fc_q.size()) begin
        check($sformatf("wrap frame_cnt[%0d]", i), 32'(fc_q[i]), (i + 1) % 4);
        $display("wrap frame %0d: frame_cnt=%0d", i, fc_q[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_readout_sequencer.md
Name: sensor_readout_sequencer

Overview:
- Generates the frame/line framing (fvals_map, lvals_map) that drives mapping_controller.
- Generates the even/odd group select used to fold the 16 trained channels onto the 8 parallel outputs.
- Sequences frames from a programmable geometry: active width, horizontal blanking, line count, vertical blanking.
- Supports single-shot and continuous capture with graceful stop. Sits between the sensor-control register bank and mapping_controller in the clk_rxg domain.

Parameters:
- CNT_W, 12, width of the geometry fields and the column/row counters.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk_rxg  in  1  receive-side pixel clock; all logic on its rising edge.
- rst_rx_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin capture.
- stop  in  1  one-cycle request to end continuous capture after the current frame.
- cfg_continuous  in  1  1 = free-run frames, 0 = single frame.
- cfg_line_len  in  CNT_W  active pixels per line, in clocks.
- cfg_hblank  in  CNT_W  clocks between lines.
- cfg_lines  in  CNT_W  lines per frame.
- cfg_vblank  in  CNT_W  clocks between frames.
- fvals_map  out  1  frame valid.
- lvals_map  out  1  line valid.
- grp_sel  out  1  channel group select: 0 = even channels, 1 = odd.
- col_cnt  out  CNT_W  column index inside the active line.
- row_cnt  out  CNT_W  current line index.
- frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W.
- frame_done  out  1  one-cycle pulse at end of the active frame.
- busy  out  1  high in every state except IDLE.
- cfg_err  out  1  one-cycle pulse: start rejected because of bad config.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; shadow config regs 0; stop_pending 0.
- All outputs are registered.
- Config validity: line_len, hblank, lines and vblank must each be nonzero.
  - Config is latched into shadow regs on an accepted start, and again at each frame boundary in continuous mode.
  - Config inputs are ignored at all other times.
- IDLE:
  - start with valid config at edge N -> LINE; fvals_map=lvals_map=1 from cycle N+1; row_cnt=0, col_cnt=0, grp_sel=0.
  - start with invalid config -> cfg_err=1 for one cycle; remain IDLE.
  - stop is ignored.
- LINE: fvals_map=1, lvals_map=1 for exactly line_len cycles.
  - col_cnt counts 0..line_len-1.
  - grp_sel toggles every cycle, starting at 0 on col 0.
  - After the last column: if row_cnt==lines-1 -> VBLANK, else -> HBLANK.
- HBLANK: fvals_map=1, lvals_map=0 for hblank cycles; col_cnt=0, grp_sel=0; then LINE with row_cnt+1.
- VBLANK: fvals_map=0, lvals_map=0 for vblank cycles; row_cnt and col_cnt held at 0.
  - frame_done=1 and frame_cnt+1 on the first VBLANK cycle.
  - At the end of VBLANK: if cfg_continuous=1 (shadow) and stop_pending=0 -> re-latch config, LINE row 0. Otherwise -> IDLE and clear stop_pending.
- Frame timing:
  - fval-high length = lines*line_len + (lines-1)*hblank.
  - Frame period = fval-high length + vblank.
- start while busy: ignored; no cfg_err.
- stop while busy:
  - Sets stop_pending; the current frame always completes.
  - stop and start in the same cycle in IDLE: start wins.
  - stop in the same cycle as the VBLANK exit: honoured; go to IDLE.
- Single-shot mode: exactly one frame, then IDLE, regardless of stop.
- Counters never exceed their programmed limits; there is no wrap inside a frame.
- frame_cnt wraps from 2^FCNT_W-1 to 0.

Test Plan:
- Reset mid-frame: assert rst_rx_n=0 during LINE, row 1 -> all outputs 0 immediately; after release, IDLE, busy=0.
- Single-shot, line_len=4, hblank=2, lines=3, vblank=5:
  - fvals_map high for 16 consecutive cycles.
  - lvals_map pattern 4 high / 2 low / 4 high / 2 low / 4 high.
  - grp_sel within each line = 0,1,0,1.
  - frame_done pulses once; frame_cnt=1; busy falls 21 cycles after fvals_map rises.
- Continuous, same geometry, stop pulsed during frame 2 line 1:
  - Frame period 21 cycles.
  - Frame 2 completes; IDLE after its VBLANK; frame_cnt=2; no third fvals_map rise.
- Bad config: cfg_hblank=0, start -> cfg_err one-cycle pulse; fvals_map stays 0; busy=0.
- Config change mid-frame: change cfg_line_len 4->8 during frame 1 (continuous) -> frame 1 lines remain 4 clocks; frame 2 lines are 8 clocks.
- frame_cnt wrap: FCNT_W=2, continuous, 5 frames -> frame_cnt sequence 1,2,3,0,1.
